branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/PC width in bits (>= 8).
REQ-002 Parameter STAT_W, default 32, width of statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 in_func3  input  3  branch condition code (RV32I B-type encoding).
REQ-008 in_rs1 / in_rs2  input  XLEN  compare operands.
REQ-009 in_pc / in_imm  input  XLEN  branch PC; sign-extended offset.
REQ-010 in_pred_taken / in_pred_target  input  1 / XLEN  front-end prediction.
REQ-011 flush  input  1  discard held result and any request accepted this cycle.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_taken, out_mispredict, out_illegal  output  1 each  resolved outcome.
REQ-014 out_redirect_pc  output  XLEN  correct next PC.
REQ-015 stat_branches, stat_mispredicts  output  STAT_W each  statistics (see REQ-031).

Function
REQ-016 Conditions: 000 beq (==), 001 bne (!=), 100 blt signed <, 101 bge signed >=, 110 bltu unsigned <, 111 bgeu unsigned >=.
REQ-017 func3 010/011: out_taken=0, out_illegal=1, out_mispredict=in_pred_taken.
REQ-018 Target = in_pc + in_imm modulo 2^XLEN; fall-through = in_pc + 4 modulo 2^XLEN.
REQ-019 out_redirect_pc = target if taken, else fall-through.
REQ-020 out_mispredict = (taken != in_pred_taken) OR (taken AND in_pred_target != target).
REQ-021 Transfer occurs when in_valid AND in_ready; result registered, out_valid next cycle (latency 1).
REQ-022 in_ready = !out_valid OR out_ready (single output register, full throughput).
REQ-023 Output fields hold stable while out_valid AND !out_ready.
REQ-024 out_valid clears after out_valid AND out_ready with no new transfer same cycle.
REQ-025 flush high: out_valid=0 next cycle regardless of out_ready or in_valid; no transfer counted.
REQ-026 Simultaneous pop and push: out_valid stays 1, fields take new request.
REQ-027 Operand extremes (signed min vs max, all-ones) resolve per REQ-016 without overflow.

Reset
REQ-028 rst asserted: out_valid=0, out_taken=0, out_mispredict=0, out_illegal=0, out_redirect_pc=0, stats=0, immediately.
REQ-029 Request in flight at reset is discarded; in_ready=1 first cycle after deassertion.

Configuration
REQ-030 Macro BRANCH_UNIT_STATS_EN selects statistics counters.
REQ-031 Defined: stat_branches increments per accepted non-flushed request, stat_mispredicts per one with mispredict=1; both saturate at 2^STAT_W-1.
REQ-032 Undefined: no counter flops; stat outputs tie to 0.

Structure
REQ-033 Package branch_pkg holds func3 enum (BEQ..BGEU) and FALLTHROUGH_OFS=4.
REQ-034 Sub-module branch_cmp (combinational, parameter XLEN): func3, rs1, rs2 -> taken, illegal.

Verification
REQ-035 blt rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, mispredict=1, redirect=pc+imm, one cycle later.
REQ-036 bge rs1=rs2=5 -> taken=1; bgeu 1 vs 0xFFFFFFFF -> taken=0, redirect=pc+4.
REQ-037 out_ready=0 for 3 cycles, in_valid held -> in_ready=0, output stable, no loss; release -> back-to-back results.
REQ-038 func3=010, pred_taken=1 -> illegal=1, taken=0, mispredict=1.
REQ-039 flush with out_valid=1 and new in_valid -> out_valid=0 next cycle, stats unchanged.
REQ-040 STATS_EN, STAT_W=4, 20 mispredicting branches -> both counters 15; rst mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_pkg.sv
// Package for the branch resolution unit.
//   - func3_e         : RV32I B-type condition codes (BEQ..BGEU)
//   - FALLTHROUGH_OFS : byte offset from the branch PC to the next sequential PC
// Optional feature macro used by the top: BRANCH_UNIT_STATS_EN.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } func3_e;

    localparam int FALLTHROUGH_OFS = 4;

endpackage

// File: rtl/branch_unit_if.sv
// Request/result bus of the branch unit.
//   Request : in_valid, in_ready, in_func3, in_rs1, in_rs2, in_pc, in_imm,
//             in_pred_taken, in_pred_target, flush
//   Result  : out_valid, out_ready, out_taken, out_mispredict, out_illegal,
//             out_redirect_pc
// slave  = branch unit side, master = producer/consumer side.
interface branch_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_func3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic [XLEN-1:0] in_pred_target;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
    logic [XLEN-1:0] out_redirect_pc;

    modport slave (
        input  in_valid, in_func3, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, flush, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_illegal,
               out_redirect_pc
    );

    modport master (
        output in_valid, in_func3, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_illegal,
               out_redirect_pc
    );
endinterface

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
//   i_func3        : B-type condition code
//   i_rs1, i_rs2   : operands
//   o_taken        : condition holds (0 for illegal codes)
//   o_illegal      : func3 is 010 or 011
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_illegal
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    // Native compares avoid the overflow a subtract-based compare would hit
    // at signed min/max operands.
    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_func3)
            BEQ:     o_taken = w_eq;
            BNE:     o_taken = !w_eq;
            BLT:     o_taken = w_lt;
            BGE:     o_taken = !w_lt;
            BLTU:    o_taken = w_ltu;
            BGEU:    o_taken = !w_ltu;
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates the branch condition, computes the correct
// next PC, flags mispredictions against the front-end prediction and presents
// the result through a single registered output stage (latency 1, full
// throughput).
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : request/result handshake, see branch_unit_if
//   stat_branches     : accepted, non-flushed branches (saturating)
//   stat_mispredicts  : accepted, non-flushed mispredicted branches (saturating)
// Macro BRANCH_UNIT_STATS_EN: when defined, statistics counters are built;
// otherwise the stat outputs are constant zero.
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_unit_if.slave      bus,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    logic            w_taken;
    logic            w_illegal;
    logic            w_mispredict;
    logic            w_in_ready;
    logic            w_push;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fallthrough;

    logic            r_out_valid;
    logic            r_out_taken;
    logic            r_out_mispredict;
    logic            r_out_illegal;
    logic [XLEN-1:0] r_out_redirect_pc;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_func3   (bus.in_func3),
        .i_rs1     (bus.in_rs1),
        .i_rs2     (bus.in_rs2),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    assign w_target      = bus.in_pc + bus.in_imm;
    assign w_fallthrough = bus.in_pc + XLEN'(FALLTHROUGH_OFS);
    // Illegal codes resolve not-taken, so this reduces to in_pred_taken there.
    assign w_mispredict  = (w_taken != bus.in_pred_taken) ||
                           (w_taken && (bus.in_pred_target != w_target));

    assign w_in_ready = !r_out_valid || bus.out_ready;
    // A request accepted in a flush cycle is discarded and not counted.
    assign w_push     = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid       <= 1'b0;
            r_out_taken       <= 1'b0;
            r_out_mispredict  <= 1'b0;
            r_out_illegal     <= 1'b0;
            r_out_redirect_pc <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_push) begin
            r_out_valid       <= 1'b1;
            r_out_taken       <= w_taken;
            r_out_mispredict  <= w_mispredict;
            r_out_illegal     <= w_illegal;
            r_out_redirect_pc <= w_taken ? w_target : w_fallthrough;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_taken       = r_out_taken;
    assign bus.out_mispredict  = r_out_mispredict;
    assign bus.out_illegal     = r_out_illegal;
    assign bus.out_redirect_pc = r_out_redirect_pc;

`ifdef BRANCH_UNIT_STATS_EN
    logic [STAT_W-1:0] r_stat_branches;
    logic [STAT_W-1:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_push) begin
            if (r_stat_branches != '1)
                r_stat_branches <= r_stat_branches + 1'b1;
            if (w_mispredict && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule
